// File: rtl/instruction_fetcher_pkg.sv
// Shared types for the warp pipeline: warp states, the instruction word and
// the fetcher's own state, which the decoder reads to gate WARP_DECODE.
package instruction_fetcher_pkg;

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

  typedef logic [31:0] instruction_t;

  typedef enum logic [1:0] {
    FETCHER_IDLE     = 2'd0,
    FETCHER_FETCHING = 2'd1,
    FETCHER_DONE     = 2'd2
  } fetcher_state_t;

endpackage

// File: rtl/instruction_fetcher.sv
// Per-warp fetch stage: reads one instruction over a valid/ready handshake,
// with a one-entry last-PC buffer and a saturating stall-cycle counter.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int INSTR_ADDR_WIDTH = 12,
  parameter int INSTR_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  warp_state_t                 warp_state,
  input  logic [INSTR_ADDR_WIDTH-1:0] pc,
  input  logic                        invalidate,
  output logic                        instruction_mem_read_valid,
  output logic [INSTR_ADDR_WIDTH-1:0] instruction_mem_read_address,
  input  logic                        instruction_mem_read_ready,
  input  logic [INSTR_WIDTH-1:0]      instruction_mem_read_data,
  output fetcher_state_t              fetcher_state,
  output instruction_t                instruction,
  output logic [STALL_CNT_WIDTH-1:0]  fetch_stall_cycles
);

  fetcher_state_t              r_state;
  logic                        r_read_valid;
  logic [INSTR_ADDR_WIDTH-1:0] r_read_address;
  instruction_t                r_instruction;
  logic [STALL_CNT_WIDTH-1:0]  r_stall_cycles;

  logic                        r_tag_valid;
  logic [INSTR_ADDR_WIDTH-1:0] r_tag;
  instruction_t                r_buf_data;

  logic w_hit;
  logic w_stall_sat;
  logic w_response;

  // Same-cycle invalidate must win over a stale buffer entry.
  assign w_hit       = r_tag_valid && (r_tag == pc) && !invalidate;
  assign w_stall_sat = &r_stall_cycles;
  assign w_response  = (r_state == FETCHER_FETCHING) && instruction_mem_read_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in this block override earlier ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= FETCHER_IDLE;
      r_read_valid   <= 1'b0;
      r_read_address <= '0;
      r_instruction  <= '0;
      r_stall_cycles <= '0;
      r_tag_valid    <= 1'b0;
    end else begin
      if (invalidate) r_tag_valid <= 1'b0;

      unique case (r_state)
        FETCHER_IDLE: begin
          if (warp_state == WARP_FETCH) begin
            if (w_hit) begin
              r_instruction <= r_buf_data;
              r_state       <= FETCHER_DONE;
            end else begin
              r_read_valid   <= 1'b1;
              r_read_address <= pc;
              r_state        <= FETCHER_FETCHING;
            end
          end
        end

        FETCHER_FETCHING: begin
          if (instruction_mem_read_ready) begin
            r_instruction <= instruction_mem_read_data;
            r_tag_valid   <= !invalidate;
            r_read_valid  <= 1'b0;
            r_state       <= FETCHER_DONE;
          end else if (!w_stall_sat) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_WIDTH'(1);
          end
        end

        FETCHER_DONE: begin
          if (warp_state == WARP_DECODE) r_state <= FETCHER_IDLE;
        end

        default: r_state <= FETCHER_IDLE;
      endcase
    end
  end

  // NOTE: buffer payload has no reset; r_tag_valid alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (w_response) begin
      r_buf_data <= instruction_mem_read_data;
      r_tag      <= r_read_address;
    end
  end

  assign instruction_mem_read_valid   = r_read_valid;
  assign instruction_mem_read_address = r_read_address;
  assign fetcher_state                = r_state;
  assign instruction                  = r_instruction;
  assign fetch_stall_cycles           = r_stall_cycles;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Randomised bench for instruction_fetcher: the bench plays program memory and
// decoder, and predicts results from a transaction-level model of the fetch stage.
module tb_instruction_fetcher;
  import instruction_fetcher_pkg::*;

  logic           clk;
  logic           reset;
  warp_state_t    warp_state;
  logic [11:0]    pc;
  logic           invalidate;
  logic           rd_valid;
  logic [11:0]    rd_addr;
  logic           rd_ready;
  logic [31:0]    rd_data;
  fetcher_state_t fstate;
  instruction_t   instr;
  logic [15:0]    stall;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: memory contents per program generation, one cached pc, stall total.
  int          gen     = 0;
  bit          m_valid = 0;
  logic [11:0] m_pc    = '0;
  int          m_stall = 0;

  instruction_fetcher #(
    .INSTR_ADDR_WIDTH(12),
    .INSTR_WIDTH     (32),
    .STALL_CNT_WIDTH (16)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .warp_state                  (warp_state),
    .pc                          (pc),
    .invalidate                  (invalidate),
    .instruction_mem_read_valid  (rd_valid),
    .instruction_mem_read_address(rd_addr),
    .instruction_mem_read_ready  (rd_ready),
    .instruction_mem_read_data   (rd_data),
    .fetcher_state               (fstate),
    .instruction                 (instr),
    .fetch_stall_cycles          (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [11:0] a, input int g);
    logic [31:0] aa;
    aa = 32'(a);
    if (a == 12'h010 && g == 0) return 32'h00500093;
    return (aa * 32'h01000193) ^ (32'(g) * 32'h9E3779B9) ^ 32'h00000013;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check_idle_outputs(input string tag, input logic [31:0] exp_instr);
    check({tag, ".state"}, 32'(fstate), 32'(FETCHER_IDLE));
    check({tag, ".valid"}, 32'(rd_valid), 32'd0);
    check({tag, ".instr"}, instr, exp_instr);
  endtask

  // One complete fetch: request (or buffer hit), response, DONE hold, DECODE hand-off.
  task automatic do_fetch(input logic [11:0] p, input bit inv, input int lat,
                          input bit inv_rdy, input bit noise);
    bit          exp_hit;
    logic [31:0] exp_d;
    int          base;
    int          hold;
    exp_hit = m_valid && (m_pc == p) && !inv;
    if (inv) begin
      gen++;
      m_valid = 0;
    end
    exp_d = mem_word(p, gen);
    base  = m_stall;

    warp_state = WARP_FETCH;
    pc         = p;
    invalidate = inv;
    rd_ready   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    rd_data    = $urandom;
    tick();
    invalidate = 1'b0;
    rd_ready   = 1'b0;

    if (exp_hit) begin
      check("hit.state", 32'(fstate), 32'(FETCHER_DONE));
      check("hit.valid", 32'(rd_valid), 32'd0);
      check("hit.instr", instr, exp_d);
    end else begin
      check("req.state", 32'(fstate), 32'(FETCHER_FETCHING));
      check("req.valid", 32'(rd_valid), 32'd1);
      check("req.addr", 32'(rd_addr), 32'(p));
      for (int i = 0; i < lat; i++) begin
        if (noise) begin
          warp_state = warp_state_t'($urandom_range(0, 7));
          pc         = 12'($urandom);
          invalidate = ($urandom_range(0, 7) == 0);
        end
        tick();
        invalidate = 1'b0;
        check("wait.valid", 32'(rd_valid), 32'd1);
        check("wait.addr", 32'(rd_addr), 32'(p));
      end
      rd_ready   = 1'b1;
      rd_data    = exp_d;
      invalidate = inv_rdy;
      tick();
      rd_ready   = 1'b0;
      rd_data    = $urandom;
      invalidate = 1'b0;
      check("rsp.state", 32'(fstate), 32'(FETCHER_DONE));
      check("rsp.valid", 32'(rd_valid), 32'd0);
      check("rsp.instr", instr, exp_d);
      m_stall = sat16(base + lat);
      m_valid = !inv_rdy;
      m_pc    = p;
    end
    check("stall", 32'(stall), 32'(m_stall));

    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      warp_state = ($urandom_range(0, 1) == 0) ? WARP_FETCH : WARP_EXECUTE;
      pc         = 12'($urandom);
      rd_ready   = 1'($urandom_range(0, 1));
      tick();
      rd_ready   = 1'b0;
      check("done.state", 32'(fstate), 32'(FETCHER_DONE));
      check("done.instr", instr, exp_d);
    end

    warp_state = WARP_DECODE;
    tick();
    warp_state = WARP_IDLE;
    check_idle_outputs("decode", exp_d);
  endtask

  // Idle gap with stray ready strobes and occasional program reloads.
  task automatic idle_gap(input int n);
    logic [31:0] held;
    for (int i = 0; i < n; i++) begin
      held       = instr;
      warp_state = WARP_IDLE;
      rd_ready   = 1'($urandom_range(0, 1));
      rd_data    = $urandom;
      invalidate = ($urandom_range(0, 5) == 0);
      if (invalidate) begin
        gen++;
        m_valid = 0;
      end
      tick();
      rd_ready   = 1'b0;
      invalidate = 1'b0;
      check_idle_outputs("gap", held);
    end
  endtask

  initial begin
    logic [11:0] pcs [4];
    logic [11:0] p;
    pcs[0] = 12'h010; pcs[1] = 12'h011; pcs[2] = 12'hFFF; pcs[3] = 12'h000;

    reset      = 1'b1;
    warp_state = WARP_IDLE;
    pc         = '0;
    invalidate = 1'b0;
    rd_ready   = 1'b0;
    rd_data    = '0;
    tick();
    tick();
    check("rst.state", 32'(fstate), 32'(FETCHER_IDLE));
    check("rst.valid", 32'(rd_valid), 32'd0);
    check("rst.addr", 32'(rd_addr), 32'd0);
    check("rst.instr", instr, 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // Directed: miss with 3-cycle latency, then a buffer hit, then invalidated refetch.
    do_fetch(12'h010, 1'b0, 3, 1'b0, 1'b0);
    check("t1.instr", instr, 32'h00500093);
    check("t1.stall", 32'(stall), 32'd3);
    do_fetch(12'h010, 1'b0, 0, 1'b0, 1'b0);
    check("t2.stall", 32'(stall), 32'd3);
    do_fetch(12'h010, 1'b1, 2, 1'b0, 1'b0);
    do_fetch(12'h010, 1'b0, 4, 1'b0, 1'b1);
    do_fetch(12'h010, 1'b0, 0, 1'b0, 1'b0);

    // Directed: reset in the middle of a request.
    gen++;
    m_valid    = 0;
    warp_state = WARP_FETCH;
    pc         = 12'h020;
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    check("t5.valid_pre", 32'(rd_valid), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("t5.state", 32'(fstate), 32'(FETCHER_IDLE));
    check("t5.valid", 32'(rd_valid), 32'd0);
    check("t5.addr", 32'(rd_addr), 32'd0);
    check("t5.instr", instr, 32'd0);
    check("t5.stall", 32'(stall), 32'd0);
    reset      = 1'b0;
    warp_state = WARP_IDLE;
    rd_ready   = 1'b1;
    rd_data    = 32'hDEADBEEF;
    tick();
    tick();
    rd_ready = 1'b0;
    check_idle_outputs("t5.late", 32'd0);
    check("t5.late_stall", 32'(stall), 32'd0);
    m_valid = 0;
    m_stall = 0;

    // Random traffic over a small pc set so hits occur often.
    for (int k = 0; k < 300; k++) begin
      p = ($urandom_range(0, 4) == 0) ? 12'($urandom) : pcs[$urandom_range(0, 3)];
      do_fetch(p, ($urandom_range(0, 9) == 0), $urandom_range(0, 5),
               ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      idle_gap($urandom_range(0, 2));
    end

    // Stall counter saturation.
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    m_valid = 0;
    m_stall = 0;
    warp_state = WARP_FETCH;
    pc         = 12'h030;
    tick();
    warp_state = WARP_IDLE;
    for (int i = 0; i < 70000; i++) tick();
    check("sat.valid", 32'(rd_valid), 32'd1);
    check("sat.stall", 32'(stall), 32'h0000FFFF);
    rd_ready = 1'b1;
    rd_data  = 32'h12345678;
    tick();
    rd_ready = 1'b0;
    check("sat.state", 32'(fstate), 32'(FETCHER_DONE));
    check("sat.instr", instr, 32'h12345678);
    check("sat.stall_after", 32'(stall), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
